store_buffer: RTL and testbench

//  Posted-write buffer between the execute stage and data memory. Queues stores
//  (word address, data) in FIFO order and retires them to memory one per accepted

---
 rtl/store_buffer_pkg.sv | 26 ++
 rtl/store_buffer_match.sv | 37 +++
 rtl/store_buffer.sv | 133 +++++++++++++
 tb/tb_store_buffer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: geometry, entry layout, FSM encoding
// and the byte-to-word address helper.
package store_buffer_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_DATA_W = 32;
    localparam int SB_ADDR_W = 30;

    // One buffered store: {valid, word address, data}.
    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

    typedef enum logic {
        SB_RUN   = 1'b0,
        SB_DRAIN = 1'b1
    } sb_state_e;

    // Byte address to word address; the two byte-lane bits are dropped.
    function automatic logic [SB_ADDR_W-1:0] sb_word_addr(input logic [31:0] byte_addr);
        return byte_addr[SB_ADDR_W+1:2];
    endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Load-forwarding lookup: scans the occupied entries in age order and returns
// the data of the youngest entry whose word address matches.
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  sb_entry_t                    entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]     head,
    input  logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic [SB_ADDR_W-1:0]         lookup_addr,
    output logic                         hit,
    output logic [SB_DATA_W-1:0]         data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Oldest-to-youngest scan; a later match overrides an earlier one, so the
    // youngest store wins. Slot index wraps naturally at PTR_W bits.
    always_comb begin
        hit  = 1'b0;
        data = {SB_DATA_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) &&
                entries[head + PTR_W'(i)].valid &&
                (entries[head + PTR_W'(i)].addr == lookup_addr)) begin
                hit  = 1'b1;
                data = entries[head + PTR_W'(i)].data;
            end else begin
                hit  = hit;
                data = data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: FIFO of stores retired to memory one per
// handshake, youngest-match load forwarding, and a fence-driven full drain.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter  int DEPTH  = SB_DEPTH,
    localparam int DATA_W = SB_DATA_W,
    localparam int ADDR_W = SB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    input  logic [31:0]       st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ready,
    input  logic              ld_valid,
    input  logic [31:0]       ld_addr,
    output logic              ld_hit,
    output logic [DATA_W-1:0] ld_data,
    output logic              mem_wr_valid,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_wr_ready,
    input  logic              fence,
    output logic              fence_done,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    sb_entry_t          entries_r [DEPTH];
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_s;
    sb_state_e          state_r;
    sb_state_e          state_s;
    logic               fence_done_r;
    logic               fence_done_s;
    logic               push_s;
    logic               pop_s;
    logic               match_hit_s;
    logic [DATA_W-1:0]  match_data_s;
    logic               unused_addr_bits_s;

    // Byte-lane bits of both addresses carry no meaning for word matching.
    assign unused_addr_bits_s = ^{st_addr[1:0], ld_addr[1:0]};

    assign st_ready     = (state_r == SB_RUN) && (count_r < CNT_W'(DEPTH));
    assign mem_wr_valid = (count_r != CNT_W'(0));
    assign mem_wr_addr  = entries_r[head_r].addr;
    assign mem_wr_data  = entries_r[head_r].data;
    assign empty        = (count_r == CNT_W'(0));
    assign fence_done   = fence_done_r;
    assign push_s       = st_valid && st_ready;
    assign pop_s        = mem_wr_valid && mem_wr_ready;

    sb_match #(
        .DEPTH (DEPTH)
    ) u_match (
        .entries     (entries_r),
        .head        (head_r),
        .count       (count_r),
        .lookup_addr (sb_word_addr(ld_addr)),
        .hit         (match_hit_s),
        .data        (match_data_s)
    );

    assign ld_hit  = ld_valid && match_hit_s;
    assign ld_data = (ld_valid && match_hit_s) ? match_data_s : {DATA_W{1'b0}};

    // Occupancy update: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_W'(1);
            2'b01:   count_s = count_r - CNT_W'(1);
            default: count_s = count_r;
        endcase
    end

    // RUN/DRAIN next state; fence_done is pre-computed so the registered pulse
    // lands in the DRAIN cycle that first sees an empty buffer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            SB_RUN: begin
                if (fence) begin
                    state_s = SB_DRAIN;
                end else begin
                    state_s = SB_RUN;
                end
            end
            SB_DRAIN: begin
                if (count_r == CNT_W'(0)) begin
                    state_s = SB_RUN;
                end else begin
                    state_s = SB_DRAIN;
                end
            end
            default: state_s = SB_RUN;
        endcase
        fence_done_s = (state_s == SB_DRAIN) && (count_s == CNT_W'(0));
    end

    // Pointers, count, FSM and entry storage; reset drops all pending stores.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_r       <= PTR_W'(0);
            tail_r       <= PTR_W'(0);
            count_r      <= CNT_W'(0);
            state_r      <= SB_RUN;
            fence_done_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i].valid <= 1'b0;
            end
        end else begin
            if (pop_s) begin
                entries_r[head_r].valid <= 1'b0;
                head_r                  <= head_r + PTR_W'(1);
            end
            if (push_s) begin
                entries_r[tail_r] <= {1'b1, sb_word_addr(st_addr), st_data};
                tail_r            <= tail_r + PTR_W'(1);
            end
            count_r      <= count_s;
            state_r      <= state_s;
            fence_done_r <= fence_done_s;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: stimulus queues expected memory writes and
// load results; a negedge monitor pops and compares whenever the DUT presents them.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        mem_wr_valid;
    logic [29:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_ready;
    logic        fence;
    logic        fence_done;
    logic        empty;

    always #5 clk = ~clk;

    store_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .st_valid     (st_valid),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_ready     (st_ready),
        .ld_valid     (ld_valid),
        .ld_addr      (ld_addr),
        .ld_hit       (ld_hit),
        .ld_data      (ld_data),
        .mem_wr_valid (mem_wr_valid),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_ready (mem_wr_ready),
        .fence        (fence),
        .fence_done   (fence_done),
        .empty        (empty)
    );

    typedef struct { logic [29:0] addr; logic [31:0] data; } wr_exp_t;
    typedef struct { logic hit; logic [31:0] data; } ld_exp_t;

    wr_exp_t wr_q[$];
    ld_exp_t ld_q[$];
    int      n_cmp = 0;
    int      n_bad = 0;
    int      done_at;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every retired write and every load lookup against the queues.
    always @(negedge clk) begin
        wr_exp_t we;
        ld_exp_t le;
        if (rst && mem_wr_valid && mem_wr_ready) begin
            if (wr_q.size() == 0) begin
                chk("wr_unexpected_valid", mem_wr_valid, 1'b0);
            end else begin
                we = wr_q.pop_front();
                chk("wr_addr", mem_wr_addr, we.addr);
                chk("wr_data", mem_wr_data, we.data);
            end
        end
        if (rst && ld_valid) begin
            if (ld_q.size() == 0) begin
                chk("ld_unexpected_valid", ld_valid, 1'b0);
            end else begin
                le = ld_q.pop_front();
                chk("ld_hit", ld_hit, le.hit);
                chk("ld_data", ld_data, le.data);
            end
        end
    end

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        while (!st_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("st_accept", st_ready, 1'b1);
        if (st_ready) wr_q.push_back('{addr: a[31:2], data: d});
        @(posedge clk); #1;
        st_valid = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic h, input logic [31:0] d);
        ld_q.push_back('{hit: h, data: d});
        ld_valid = 1'b1;
        ld_addr  = a;
        @(posedge clk); #1;
        ld_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (!empty && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", empty, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; st_valid = 1'b1; st_addr = 32'h40; st_data = 32'h99;
        ld_valid = 1'b0; ld_addr = 32'h0; mem_wr_ready = 1'b1; fence = 1'b0;

        // 1: reset held with a store offered
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_st_ready", st_ready, 1'b1);
        chk("rst_empty", empty, 1'b1);
        chk("rst_mem_wr_valid", mem_wr_valid, 1'b0);
        chk("rst_fence_done", fence_done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1; st_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_empty", empty, 1'b1);
        chk("post_rst_mem_wr_valid", mem_wr_valid, 1'b0);
        chk("idle_ld_hit", ld_hit, 1'b0);
        chk("idle_ld_data", ld_data, 32'h0);
        @(posedge clk); #1;
        do_load(32'h40, 1'b0, 32'h0);

        // 2: fill, hold a fifth store, then retire in order
        mem_wr_ready = 1'b0;
        do_store(32'h10, 32'hA);
        do_store(32'h14, 32'hB);
        do_store(32'h18, 32'hC);
        do_store(32'h1C, 32'hD);
        chk("full_st_ready", st_ready, 1'b0);
        chk("full_empty", empty, 1'b0);
        st_valid = 1'b1; st_addr = 32'h30; st_data = 32'hE;
        repeat (2) begin
            @(negedge clk);
            chk("held_st_ready", st_ready, 1'b0);
            chk("held_head_addr", mem_wr_addr, 30'h4);
            @(posedge clk); #1;
        end
        mem_wr_ready = 1'b1;
        do_store(32'h30, 32'hE);
        wait_empty();

        // 3: forwarding of the youngest duplicate
        mem_wr_ready = 1'b0;
        do_store(32'h20, 32'h11);
        do_store(32'h20, 32'h22);
        do_load(32'h23, 1'b1, 32'h22);
        do_load(32'h24, 1'b0, 32'h0);
        ld_addr = 32'h20;
        @(negedge clk);
        chk("novalid_ld_hit", ld_hit, 1'b0);
        chk("novalid_ld_data", ld_data, 32'h0);
        @(posedge clk); #1;
        mem_wr_ready = 1'b1;
        wait_empty();

        // 4: push and pop in the same cycle with count 2
        mem_wr_ready = 1'b0;
        do_store(32'h40, 32'h41);
        do_store(32'h44, 32'h42);
        mem_wr_ready = 1'b1; st_valid = 1'b1; st_addr = 32'h48; st_data = 32'h43;
        ld_valid = 1'b1; ld_addr = 32'h40;
        wr_q.push_back('{addr: 30'h12, data: 32'h43});
        ld_q.push_back('{hit: 1'b1, data: 32'h41});
        @(negedge clk);
        chk("simul_st_ready", st_ready, 1'b1);
        @(posedge clk); #1;
        st_addr = 32'h4C; st_data = 32'h44; ld_addr = 32'h4C;
        wr_q.push_back('{addr: 30'h13, data: 32'h44});
        ld_q.push_back('{hit: 1'b0, data: 32'h0});
        @(posedge clk); #1;
        st_valid = 1'b0; ld_valid = 1'b0; mem_wr_ready = 1'b0;
        @(negedge clk);
        chk("simul_empty", empty, 1'b0);
        chk("simul_not_full", st_ready, 1'b1);
        chk("simul_head_addr", mem_wr_addr, 30'h12);
        @(posedge clk); #1;
        do_load(32'h48, 1'b1, 32'h43);
        do_load(32'h44, 1'b0, 32'h0);
        do_load(32'h4C, 1'b1, 32'h44);
        mem_wr_ready = 1'b1;
        wait_empty();

        // 5: fence with 3 entries, memory ready every other cycle
        mem_wr_ready = 1'b0;
        do_store(32'h50, 32'h1);
        do_store(32'h54, 32'h2);
        do_store(32'h58, 32'h3);
        fence = 1'b1;
        @(posedge clk); #1;
        fence = 1'b0;
        st_valid = 1'b1; st_addr = 32'h5C; st_data = 32'h4;
        done_at = -1;
        for (int c = 0; c < 40 && done_at < 0; c++) begin
            mem_wr_ready = c[0];
            @(negedge clk);
            chk("drain_st_ready", st_ready, 1'b0);
            if (fence_done) begin
                done_at = c;
                chk("done_empty", empty, 1'b1);
            end
            @(posedge clk); #1;
        end
        chk("fence_done_cycle", done_at, 64'd6);
        mem_wr_ready = 1'b0;
        wr_q.push_back('{addr: 30'h17, data: 32'h4});
        @(negedge clk);
        chk("post_fence_pulse", fence_done, 1'b0);
        chk("post_fence_st_ready", st_ready, 1'b1);
        @(posedge clk); #1;
        st_valid = 1'b0;
        mem_wr_ready = 1'b1;
        wait_empty();
        fence = 1'b1;
        @(posedge clk); #1;
        fence = 1'b0;
        @(negedge clk);
        chk("empty_fence_done", fence_done, 1'b1);
        chk("empty_fence_st_ready", st_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("empty_fence_pulse", fence_done, 1'b0);
        chk("empty_fence_run", st_ready, 1'b1);
        @(posedge clk); #1;

        // 6: ten stores through the ring, forwarding across wrap, then mid-run reset
        mem_wr_ready = 1'b1;
        for (int i = 0; i < 7; i++) do_store(32'h100 + 32'(4 * i), 32'h1000 + 32'(i));
        do_load(32'h118, 1'b1, 32'h1006);
        for (int i = 7; i < 10; i++) do_store(32'h100 + 32'(4 * i), 32'h1000 + 32'(i));
        wait_empty();
        mem_wr_ready = 1'b0;
        do_store(32'h200, 32'hA0);
        do_store(32'h204, 32'hA1);
        do_store(32'h208, 32'hA2);
        do_store(32'h200, 32'hA3);
        do_load(32'h200, 1'b1, 32'hA3);
        do_load(32'h204, 1'b1, 32'hA1);
        do_load(32'h20C, 1'b0, 32'h0);
        mem_wr_ready = 1'b1;
        wait_empty();
        mem_wr_ready = 1'b0;
        do_store(32'h300, 32'hB0);
        do_store(32'h304, 32'hB1);
        rst = 1'b0;
        wr_q.delete();
        @(posedge clk); #1;
        rst = 1'b1; mem_wr_ready = 1'b1;
        @(negedge clk);
        chk("midrst_empty", empty, 1'b1);
        chk("midrst_st_ready", st_ready, 1'b1);
        repeat (4) begin
            chk("midrst_no_wr", mem_wr_valid, 1'b0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        do_load(32'h300, 1'b0, 32'h0);

        chk("wr_q_drained", wr_q.size(), 64'd0);
        chk("ld_q_drained", ld_q.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
